// File: rtl/rcpu_mc_pkg.sv
// Shared definitions for the rcpu_mc multicycle core: opcodes, branch conditions,
// controller states, ALU function codes and flag bit positions.
package rcpu_mc_pkg;

  typedef enum logic [3:0] {
    OpNop  = 4'h0,
    OpLdi  = 4'h1,
    OpLdw  = 4'h2,
    OpAdd  = 4'h3,
    OpSub  = 4'h4,
    OpAnd  = 4'h5,
    OpOr   = 4'h6,
    OpXor  = 4'h7,
    OpAdc  = 4'h8,
    OpLd   = 4'h9,
    OpSt   = 4'hA,
    OpBr   = 4'hB,
    OpJr   = 4'hC,
    OpMul  = 4'hD,
    OpHalt = 4'hE,
    OpIll  = 4'hF
  } op_e;

  typedef enum logic [1:0] {
    CondAlways = 2'b00,
    CondZ      = 2'b01,
    CondNz     = 2'b10,
    CondC      = 2'b11
  } cond_e;

  typedef enum logic [2:0] {
    StFetch,
    StExec,
    StImm,
    StMemRd,
    StMemWr,
    StHalt
  } state_e;

  typedef enum logic [2:0] {
    AluAdd,
    AluSub,
    AluAnd,
    AluOr,
    AluXor,
    AluAdc,
    AluMul
  } alu_func_e;

  // Flags are packed {c,n,z,v}
  localparam int unsigned FlagC = 3;
  localparam int unsigned FlagN = 2;
  localparam int unsigned FlagZ = 1;
  localparam int unsigned FlagV = 0;

  function automatic logic cond_met(cond_e cond, logic [3:0] flg);
    logic taken;
    unique case (cond)
      CondAlways: taken = 1'b1;
      CondZ:      taken = flg[FlagZ];
      CondNz:     taken = ~flg[FlagZ];
      CondC:      taken = flg[FlagC];
      default:    taken = 1'b0;
    endcase
    return taken;
  endfunction

endpackage

// File: rtl/rcpu_mc_alu.sv
// Combinational ALU for rcpu_mc. Multiplier only exists when RCPU_MC_MUL_EN is defined.
module rcpu_mc_alu
  import rcpu_mc_pkg::*;
#(
  parameter int unsigned W = 16
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         ci,
  input  alu_func_e    func,
  output logic [W-1:0] y,
  output logic         c,
  output logic         n,
  output logic         z,
  output logic         v
);

  logic [W:0] sum;

  always_comb begin
    sum = '0;
    y   = '0;
    c   = 1'b0;
    v   = 1'b0;
    unique case (func)
      AluAdd, AluAdc: begin
        sum = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, (func == AluAdc) & ci};
        y   = sum[W-1:0];
        c   = sum[W];
        v   = (a[W-1] == b[W-1]) && (y[W-1] != a[W-1]);
      end
      AluSub: begin
        // c is the carry out of a + ~b + 1, i.e. set when no borrow occurs
        sum = {1'b0, a} + {1'b0, ~b} + {{W{1'b0}}, 1'b1};
        y   = sum[W-1:0];
        c   = sum[W];
        v   = (a[W-1] != b[W-1]) && (y[W-1] != a[W-1]);
      end
      AluAnd: y = a & b;
      AluOr:  y = a | b;
      AluXor: y = a ^ b;
      AluMul: begin
`ifdef RCPU_MC_MUL_EN
        y = a * b;
`else
        y = '0;
`endif
      end
      default: y = '0;
    endcase
    n = y[W-1];
    z = (y == '0);
  end

endmodule

// File: rtl/rcpu_mc.sv
// Multicycle RCPU core: 4 GPRs, flags, PC, IR and the fetch/exec/memory controller.
// Define RCPU_MC_MUL_EN to enable the MUL opcode; otherwise it traps as illegal.
module rcpu_mc
  import rcpu_mc_pkg::*;
#(
  parameter int unsigned W        = 16,
  parameter int unsigned AW       = 16,
  parameter int unsigned RESET_PC = 0
) (
  input  logic          clk,
  input  logic          rst,
  output logic          memReq,
  input  logic          memAck,
  output logic [AW-1:0] memAddr,
  output logic          memWE,
  output logic [W-1:0]  memWrite,
  input  logic [W-1:0]  memRead,
  output logic          halted,
  output logic          illegal,
  output logic [3:0]    flags
);

  state_e        state;
  logic [AW-1:0] pc;
  logic [AW-1:0] exec_pc;
  logic [15:0]   ir;
  logic [W-1:0]  regs [4];
  logic [3:0]    flag_q;

  op_e          op;
  logic [1:0]   rd;
  logic [1:0]   rs;
  logic [W-1:0] imm_sext;
  logic [W-1:0] opa;
  logic [W-1:0] opb;
  alu_func_e    alu_func;
  logic [W-1:0] alu_y;
  logic         alu_c;
  logic         alu_n;
  logic         alu_z;
  logic         alu_v;

  assign op       = op_e'(ir[15:12]);
  assign rd       = ir[11:10];
  assign rs       = ir[9:8];
  assign imm_sext = {{(W-8){ir[7]}}, ir[7:0]};
  assign opa      = regs[rd];
  assign opb      = regs[rs];
  assign flags    = flag_q;

  always_comb begin
    alu_func = AluAdd;
    case (op)
      OpSub:   alu_func = AluSub;
      OpAnd:   alu_func = AluAnd;
      OpOr:    alu_func = AluOr;
      OpXor:   alu_func = AluXor;
      OpAdc:   alu_func = AluAdc;
      OpMul:   alu_func = AluMul;
      default: alu_func = AluAdd;
    endcase
  end

  // PC already points past the branch when EXEC runs
  always_comb begin
    exec_pc = pc;
    if (op == OpBr && cond_met(cond_e'(rd), flag_q)) begin
      exec_pc = pc + AW'(imm_sext);
    end else if (op == OpJr) begin
      exec_pc = opb[AW-1:0];
    end
  end

  rcpu_mc_alu #(
    .W (W)
  ) u_alu (
    .a    (opa),
    .b    (opb),
    .ci   (flag_q[FlagC]),
    .func (alu_func),
    .y    (alu_y),
    .c    (alu_c),
    .n    (alu_n),
    .z    (alu_z),
    .v    (alu_v)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= StFetch;
      pc       <= AW'(RESET_PC);
      ir       <= '0;
      flag_q   <= '0;
      for (int i = 0; i < 4; i++) regs[i] <= '0;
      memReq   <= 1'b0;
      memAddr  <= '0;
      memWE    <= 1'b0;
      memWrite <= '0;
      halted   <= 1'b0;
      illegal  <= 1'b0;
    end else begin
      unique case (state)
        StFetch: begin
          // Only after reset is FETCH entered without a request already raised
          if (!memReq) begin
            memReq  <= 1'b1;
            memAddr <= pc;
            memWE   <= 1'b0;
          end else if (memAck) begin
            ir     <= memRead[15:0];
            pc     <= pc + AW'(1);
            memReq <= 1'b0;
            state  <= StExec;
          end
        end
        StExec: begin
          state   <= StFetch;
          memReq  <= 1'b1;
          memWE   <= 1'b0;
          memAddr <= exec_pc;
          pc      <= exec_pc;
          case (op)
            OpLdi: regs[rd] <= imm_sext;
            OpLdw: state <= StImm;
            OpAdd, OpSub, OpAnd, OpOr, OpXor, OpAdc: begin
              regs[rd] <= alu_y;
              flag_q   <= {alu_c, alu_n, alu_z, alu_v};
            end
`ifdef RCPU_MC_MUL_EN
            OpMul: begin
              regs[rd] <= alu_y;
              flag_q   <= {alu_c, alu_n, alu_z, alu_v};
            end
`else
            OpMul: begin
              state   <= StHalt;
              memReq  <= 1'b0;
              halted  <= 1'b1;
              illegal <= 1'b1;
            end
`endif
            OpLd: begin
              state   <= StMemRd;
              memAddr <= opb[AW-1:0];
            end
            OpSt: begin
              state    <= StMemWr;
              memAddr  <= opb[AW-1:0];
              memWE    <= 1'b1;
              memWrite <= opa;
            end
            OpHalt: begin
              state  <= StHalt;
              memReq <= 1'b0;
              halted <= 1'b1;
            end
            OpIll: begin
              state   <= StHalt;
              memReq  <= 1'b0;
              halted  <= 1'b1;
              illegal <= 1'b1;
            end
            default: ;
          endcase
        end
        StImm: begin
          if (memAck) begin
            regs[rd] <= memRead;
            pc       <= pc + AW'(1);
            memAddr  <= pc + AW'(1);
            state    <= StFetch;
          end
        end
        StMemRd: begin
          if (memAck) begin
            regs[rd] <= memRead;
            memAddr  <= pc;
            state    <= StFetch;
          end
        end
        StMemWr: begin
          if (memAck) begin
            memWE   <= 1'b0;
            memAddr <= pc;
            state   <= StFetch;
          end
        end
        StHalt: ;
        default: begin
          state  <= StHalt;
          memReq <= 1'b0;
          halted <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rcpu_mc.sv
// Directed self-checking bench for rcpu_mc with a 256-word memory model and
// configurable wait states on the data region (addresses >= 0x40).
module tb_rcpu_mc;

  localparam int W  = 16;
  localparam int AW = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          memReq;
  logic          memAck = 1'b0;
  logic [AW-1:0] memAddr;
  logic          memWE;
  logic [W-1:0]  memWrite;
  logic [W-1:0]  memRead;
  logic          halted;
  logic          illegal;
  logic [3:0]    flags;

  logic [15:0] mem [256];
  int n_cmp = 0;
  int n_bad = 0;
  int data_wait = 0;
  bit hold_ack = 1'b0;
  int ack_cnt = -1;

  always #5 clk = ~clk;

  rcpu_mc #(
    .W        (W),
    .AW       (AW),
    .RESET_PC (0)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .memReq   (memReq),
    .memAck   (memAck),
    .memAddr  (memAddr),
    .memWE    (memWE),
    .memWrite (memWrite),
    .memRead  (memRead),
    .halted   (halted),
    .illegal  (illegal),
    .flags    (flags)
  );

  assign memRead = mem[memAddr[7:0]];

  always @(posedge clk) begin
    if (memReq && memAck && memWE) mem[memAddr[7:0]] <= memWrite;
  end

  // Ack responder: a fresh transfer reloads the wait count from its address
  always @(negedge clk) begin
    if (!memReq) begin
      memAck  = 1'b0;
      ack_cnt = -1;
    end else begin
      if (memAck || ack_cnt < 0) ack_cnt = (memAddr >= 16'h0040) ? data_wait : 0;
      if (hold_ack) memAck = 1'b0;
      else if (ack_cnt == 0) memAck = 1'b1;
      else begin
        memAck = 1'b0;
        ack_cnt--;
      end
    end
  end

  task automatic clear_mem();
    for (int i = 0; i < 256; i++) mem[i] <= 16'hE000;
  endtask

  task automatic load(input int addr, input logic [15:0] w);
    mem[addr] <= w;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic run_to_halt(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (halted) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_alu_basic();
    bit ok;
    clear_mem();
    load(0, 16'h107F); load(1, 16'h1401); load(2, 16'h3100);
    load(3, 16'h1850); load(4, 16'hA200); load(5, 16'hE000);
    do_reset();
    run_to_halt(ok);
    n_cmp++; if (ok !== 1'b1) begin n_bad++; $display("FAIL alu_basic_timeout: got %0b want 1", ok); end
    n_cmp++; if (mem[8'h50] !== 16'h0080) begin n_bad++; $display("FAIL alu_basic_r0: got %h want 0080", mem[8'h50]); end
    n_cmp++; if (flags !== 4'b0000) begin n_bad++; $display("FAIL alu_basic_flags: got %b want 0000", flags); end
    n_cmp++; if (illegal !== 1'b0) begin n_bad++; $display("FAIL alu_basic_illegal: got %b want 0", illegal); end
    n_cmp++; if (memReq !== 1'b0) begin n_bad++; $display("FAIL alu_basic_halt_req: got %b want 0", memReq); end
  endtask

  task automatic test_reset();
    bit ok;
    load(0, 16'h3100); load(1, 16'h3200); load(2, 16'h3300);
    load(3, 16'hA000); load(4, 16'hE000);
    hold_ack = 1'b1;
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    n_cmp++; if (memReq !== 1'b1) begin n_bad++; $display("FAIL reset_fetch_req: got %b want 1", memReq); end
    n_cmp++; if (memAddr !== 16'h0000) begin n_bad++; $display("FAIL reset_fetch_addr: got %h want 0000", memAddr); end
    @(posedge clk);
    #2 rst = 1'b0;
    #1;
    n_cmp++; if (memReq !== 1'b0) begin n_bad++; $display("FAIL reset_async_req: got %b want 0", memReq); end
    n_cmp++; if (halted !== 1'b0 || illegal !== 1'b0) begin
      n_bad++; $display("FAIL reset_status: got %b%b want 00", halted, illegal);
    end
    n_cmp++; if (flags !== 4'b0000) begin n_bad++; $display("FAIL reset_flags: got %b want 0000", flags); end
    @(negedge clk);
    hold_ack = 1'b0;
    rst = 1'b1;
    run_to_halt(ok);
    n_cmp++; if (ok !== 1'b1) begin n_bad++; $display("FAIL reset_timeout: got %0b want 1", ok); end
    n_cmp++; if (mem[0] !== 16'h0000) begin n_bad++; $display("FAIL reset_regs_zero: got %h want 0000", mem[0]); end
    n_cmp++; if (flags !== 4'b0010) begin n_bad++; $display("FAIL reset_zero_flags: got %b want 0010", flags); end
  endtask

  task automatic test_carry();
    bit seen = 1'b0;
    logic [3:0] f4 = 4'h0;
    clear_mem();
    load(0, 16'h2800); load(1, 16'hFFFF); load(2, 16'h1C01); load(3, 16'h3B00);
    load(4, 16'h8F00); load(5, 16'h1050); load(6, 16'hA800); load(7, 16'h1051);
    load(8, 16'hAC00); load(9, 16'hE000);
    do_reset();
    for (int i = 0; i < 400 && !halted; i++) begin
      @(negedge clk);
      if (!seen && memReq && !memWE && memAddr == 16'h0004) begin
        seen = 1'b1;
        f4   = flags;
      end
    end
    n_cmp++; if (halted !== 1'b1) begin n_bad++; $display("FAIL carry_timeout: got %b want 1", halted); end
    n_cmp++; if (f4 !== 4'b1010) begin n_bad++; $display("FAIL carry_add_flags: got %b want 1010", f4); end
    n_cmp++; if (mem[8'h50] !== 16'h0000) begin n_bad++; $display("FAIL carry_r2: got %h want 0000", mem[8'h50]); end
    n_cmp++; if (mem[8'h51] !== 16'h0003) begin n_bad++; $display("FAIL carry_adc_r3: got %h want 0003", mem[8'h51]); end
    n_cmp++; if (flags !== 4'b0000) begin n_bad++; $display("FAIL carry_adc_flags: got %b want 0000", flags); end
  endtask

  task automatic test_mem_wait();
    int cyc = 0;
    int t2 = -1;
    int t3 = -1;
    int t4 = -1;
    int we_cyc = 0;
    bit prev_req = 1'b0;
    bit prev_we = 1'b0;
    logic [15:0] prev_addr = 16'h0;
    clear_mem();
    load(0, 16'h1034); load(1, 16'h1440); load(2, 16'hA100); load(3, 16'h9900);
    load(4, 16'h1441); load(5, 16'hA900); load(6, 16'hE000);
    data_wait = 3;
    do_reset();
    for (int i = 0; i < 400 && !halted; i++) begin
      @(negedge clk);
      cyc++;
      if (memReq && !memWE && (!prev_req || prev_we || memAddr != prev_addr)) begin
        if (memAddr == 16'h0002 && t2 < 0) t2 = cyc;
        if (memAddr == 16'h0003 && t3 < 0) t3 = cyc;
        if (memAddr == 16'h0004 && t4 < 0) t4 = cyc;
      end
      if (memReq && memWE && t3 < 0) begin
        we_cyc++;
        n_cmp++;
        if (memAddr !== 16'h0040 || memWrite !== 16'h0034) begin
          n_bad++;
          $display("FAIL st_hold cyc %0d: got addr %h data %h want 0040 0034", cyc, memAddr, memWrite);
        end
      end
      prev_req  = memReq;
      prev_we   = memWE;
      prev_addr = memAddr;
    end
    data_wait = 0;
    n_cmp++; if (halted !== 1'b1) begin n_bad++; $display("FAIL wait_timeout: got %b want 1", halted); end
    n_cmp++; if (t3 - t2 !== 6) begin n_bad++; $display("FAIL st_cycles: got %0d want 6", t3 - t2); end
    n_cmp++; if (t4 - t3 !== 6) begin n_bad++; $display("FAIL ld_cycles: got %0d want 6", t4 - t3); end
    n_cmp++; if (we_cyc !== 4) begin n_bad++; $display("FAIL st_req_cycles: got %0d want 4", we_cyc); end
    n_cmp++; if (mem[8'h40] !== 16'h0034) begin n_bad++; $display("FAIL st_data: got %h want 0034", mem[8'h40]); end
    n_cmp++; if (mem[8'h41] !== 16'h0034) begin n_bad++; $display("FAIL ld_data: got %h want 0034", mem[8'h41]); end
  endtask

  task automatic test_branch();
    logic [15:0] exp_tr [8];
    logic [15:0] tr [8];
    int ntr = 0;
    bit prev_req = 1'b0;
    exp_tr = '{16'd0, 16'd1, 16'd2, 16'd5, 16'd6, 16'd8, 16'd9, 16'd7};
    for (int i = 0; i < 8; i++) tr[i] = 16'hFFFF;
    clear_mem();
    load(0, 16'h4000); load(1, 16'hB805); load(2, 16'hBC02); load(3, 16'hE000);
    load(4, 16'hE000); load(5, 16'h1C08); load(6, 16'hC300); load(7, 16'hE000);
    load(8, 16'h0000); load(9, 16'hB4FD);
    do_reset();
    for (int i = 0; i < 400 && !halted; i++) begin
      @(negedge clk);
      if (memReq && !prev_req && !memWE) begin
        if (ntr < 8) tr[ntr] = memAddr;
        ntr++;
      end
      prev_req = memReq;
    end
    n_cmp++; if (ntr !== 8) begin n_bad++; $display("FAIL br_fetch_count: got %0d want 8", ntr); end
    for (int i = 0; i < 8; i++) begin
      n_cmp++;
      if (tr[i] !== exp_tr[i]) begin
        n_bad++;
        $display("FAIL br_trace[%0d]: got %h want %h", i, tr[i], exp_tr[i]);
      end
    end
    n_cmp++; if (flags !== 4'b1010) begin n_bad++; $display("FAIL br_sub_flags: got %b want 1010", flags); end
    n_cmp++; if (illegal !== 1'b0) begin n_bad++; $display("FAIL br_illegal: got %b want 0", illegal); end
  endtask

  task automatic test_mul();
    bit ok;
`ifdef RCPU_MC_MUL_EN
    logic [15:0] exp_mem = 16'h0120;
    logic        exp_ill = 1'b0;
`else
    logic [15:0] exp_mem = 16'hE000;
    logic        exp_ill = 1'b1;
`endif
    clear_mem();
    load(0, 16'h1012); load(1, 16'h1410); load(2, 16'hD100);
    load(3, 16'h1850); load(4, 16'hA200); load(5, 16'hE000);
    do_reset();
    run_to_halt(ok);
    repeat (4) @(negedge clk);
    n_cmp++; if (ok !== 1'b1) begin n_bad++; $display("FAIL mul_timeout: got %0b want 1", ok); end
    n_cmp++; if (mem[8'h50] !== exp_mem) begin n_bad++; $display("FAIL mul_result: got %h want %h", mem[8'h50], exp_mem); end
    n_cmp++; if (illegal !== exp_ill) begin n_bad++; $display("FAIL mul_illegal: got %b want %b", illegal, exp_ill); end
    n_cmp++; if (flags !== 4'b0000) begin n_bad++; $display("FAIL mul_flags: got %b want 0000", flags); end
    n_cmp++; if (memReq !== 1'b0) begin n_bad++; $display("FAIL mul_halt_req: got %b want 0", memReq); end
  endtask

  task automatic test_illegal_op();
    bit ok;
    clear_mem();
    load(0, 16'hF000);
    do_reset();
    run_to_halt(ok);
    repeat (5) @(negedge clk);
    n_cmp++; if (ok !== 1'b1 || halted !== 1'b1) begin n_bad++; $display("FAIL ill_halted: got %b want 1", halted); end
    n_cmp++; if (illegal !== 1'b1) begin n_bad++; $display("FAIL ill_flag: got %b want 1", illegal); end
    n_cmp++; if (memReq !== 1'b0) begin n_bad++; $display("FAIL ill_req: got %b want 0", memReq); end
    rst = 1'b0;
    #1;
    n_cmp++; if (halted !== 1'b0 || illegal !== 1'b0) begin
      n_bad++; $display("FAIL ill_reset_clear: got %b%b want 00", halted, illegal);
    end
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    test_alu_basic();
    test_reset();
    test_carry();
    test_mem_wait();
    test_branch();
    test_mul();
    test_illegal_op();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
